// File: rtl/int_alu_fu.sv
// Integer ALU functional unit: 2-stage ALU pipe feeding a credit-managed CDB result FIFO.
// Optional macro ALU_CDB_BYPASS_EN lets S2 drive the CDB directly when the FIFO is empty.
module int_alu_fu #(
   parameter int XLEN             = 32,
   parameter int RS_TAG_WIDTH     = 3,
   parameter int RESULT_BUF_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    issue_valid,
   output logic                    issue_ready,
   input  logic [XLEN-1:0]         issue_op1,
   input  logic [XLEN-1:0]         issue_op2,
   input  logic [3:0]              issue_op,
   input  logic [RS_TAG_WIDTH-1:0] issue_tag,
   output logic                    cdb_req,
   input  logic                    cdb_grant,
   output logic [XLEN-1:0]         cdb_result,
   output logic [RS_TAG_WIDTH-1:0] cdb_tag,
   output logic                    busy
);

   localparam int SH_W  = $clog2(XLEN);
   localparam int PTR_W = $clog2(RESULT_BUF_DEPTH);
   localparam int CNT_W = $clog2(RESULT_BUF_DEPTH + 1);
   localparam int OCC_W = CNT_W + 2;

   localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RESULT_BUF_DEPTH - 1);
   localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(RESULT_BUF_DEPTH);

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_SLL   = 4'd2;
   localparam logic [3:0] OP_SLT   = 4'd3;
   localparam logic [3:0] OP_SLTU  = 4'd4;
   localparam logic [3:0] OP_XOR   = 4'd5;
   localparam logic [3:0] OP_SRL   = 4'd6;
   localparam logic [3:0] OP_SRA   = 4'd7;
   localparam logic [3:0] OP_OR    = 4'd8;
   localparam logic [3:0] OP_AND   = 4'd9;
   localparam logic [3:0] OP_PASSB = 4'd10;

   logic                    s1_v_q, s1_v_d;
   logic [XLEN-1:0]         s1_a_q, s1_a_d;
   logic [XLEN-1:0]         s1_b_q, s1_b_d;
   logic [3:0]              s1_op_q, s1_op_d;
   logic [RS_TAG_WIDTH-1:0] s1_tag_q, s1_tag_d;

   logic                    s2_v_q, s2_v_d;
   logic [XLEN-1:0]         s2_res_q, s2_res_d;
   logic [RS_TAG_WIDTH-1:0] s2_tag_q, s2_tag_d;

   logic [XLEN-1:0]         mem_res_q [RESULT_BUF_DEPTH];
   logic [XLEN-1:0]         mem_res_d [RESULT_BUF_DEPTH];
   logic [RS_TAG_WIDTH-1:0] mem_tag_q [RESULT_BUF_DEPTH];
   logic [RS_TAG_WIDTH-1:0] mem_tag_d [RESULT_BUF_DEPTH];
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   logic [XLEN-1:0]         alu_res;
   logic [SH_W-1:0]         shamt;
   logic                    fifo_empty;
   logic                    byp;
   logic                    grant_ok;
   logic                    push;
   logic                    pop;
   logic                    accept;
   logic [OCC_W-1:0]        occ;
   logic [XLEN-1:0]         head_res;
   logic [RS_TAG_WIDTH-1:0] head_tag;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_MAX) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      alu_res = '0;
      shamt   = s1_b_q[SH_W-1:0];
      case (s1_op_q)
         OP_ADD:   alu_res = s1_a_q + s1_b_q;
         OP_SUB:   alu_res = s1_a_q - s1_b_q;
         OP_SLL:   alu_res = s1_a_q << shamt;
         OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(s1_a_q) < $signed(s1_b_q)};
         OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, s1_a_q < s1_b_q};
         OP_XOR:   alu_res = s1_a_q ^ s1_b_q;
         OP_SRL:   alu_res = s1_a_q >> shamt;
         OP_SRA:   alu_res = $unsigned($signed(s1_a_q) >>> shamt);
         OP_OR:    alu_res = s1_a_q | s1_b_q;
         OP_AND:   alu_res = s1_a_q & s1_b_q;
         OP_PASSB: alu_res = s1_b_q;
         default:  alu_res = '0;
      endcase
   end

   assign fifo_empty = (cnt_q == '0);

`ifdef ALU_CDB_BYPASS_EN
   assign byp = fifo_empty && s2_v_q;
`else
   assign byp = 1'b0;
`endif

   assign head_res = byp ? s2_res_q : mem_res_q[rd_ptr_q];
   assign head_tag = byp ? s2_tag_q : mem_tag_q[rd_ptr_q];

   // Outputs read zero while idle so no stale entry is ever visible.
   assign cdb_req    = !fifo_empty || byp;
   assign cdb_result = cdb_req ? head_res : '0;
   assign cdb_tag    = cdb_req ? head_tag : '0;

   assign grant_ok = cdb_req && cdb_grant && !flush;
   assign pop      = grant_ok && !byp;
   assign push     = s2_v_q && !flush && !(byp && grant_ok);

   // Credits count every op that will eventually need a FIFO slot.
   assign occ = OCC_W'(cnt_q) + OCC_W'(s1_v_q) + OCC_W'(s2_v_q);
   assign issue_ready = (occ < DEPTH_C);
   assign accept      = issue_valid && issue_ready && !flush;
   assign busy        = s1_v_q || s2_v_q || !fifo_empty;

   always_comb begin
      s1_v_d   = accept;
      s1_a_d   = s1_a_q;
      s1_b_d   = s1_b_q;
      s1_op_d  = s1_op_q;
      s1_tag_d = s1_tag_q;
      if (accept) begin
         s1_a_d   = issue_op1;
         s1_b_d   = issue_op2;
         s1_op_d  = issue_op;
         s1_tag_d = issue_tag;
      end

      s2_v_d   = s1_v_q && !flush;
      s2_res_d = s1_v_q ? alu_res : s2_res_q;
      s2_tag_d = s1_v_q ? s1_tag_q : s2_tag_q;

      mem_res_d = mem_res_q;
      mem_tag_d = mem_tag_q;
      if (push) begin
         mem_res_d[wr_ptr_q] = s2_res_q;
         mem_tag_d[wr_ptr_q] = s2_tag_q;
      end

      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q    <= 1'b0;
         s1_a_q    <= '0;
         s1_b_q    <= '0;
         s1_op_q   <= '0;
         s1_tag_q  <= '0;
         s2_v_q    <= 1'b0;
         s2_res_q  <= '0;
         s2_tag_q  <= '0;
         mem_res_q <= '{default: '0};
         mem_tag_q <= '{default: '0};
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
      end else begin
         s1_v_q    <= s1_v_d;
         s1_a_q    <= s1_a_d;
         s1_b_q    <= s1_b_d;
         s1_op_q   <= s1_op_d;
         s1_tag_q  <= s1_tag_d;
         s2_v_q    <= s2_v_d;
         s2_res_q  <= s2_res_d;
         s2_tag_q  <= s2_tag_d;
         mem_res_q <= mem_res_d;
         mem_tag_q <= mem_tag_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
      end
   end

endmodule

// File: tb/tb_int_alu_fu.sv
// Bench for int_alu_fu: vector table through a result scoreboard,
// plus hand sequences for latency, backpressure, streaming, flush and reset.
module tb_int_alu_fu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        issue_valid;
   logic        issue_ready;
   logic [31:0] issue_op1;
   logic [31:0] issue_op2;
   logic [3:0]  issue_op;
   logic [2:0]  issue_tag;
   logic        cdb_req;
   logic        cdb_grant;
   logic [31:0] cdb_result;
   logic [2:0]  cdb_tag;
   logic        busy;

`ifdef ALU_CDB_BYPASS_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 3;
`endif

   int_alu_fu dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_op1   (issue_op1),
      .issue_op2   (issue_op2),
      .issue_op    (issue_op),
      .issue_tag   (issue_tag),
      .cdb_req     (cdb_req),
      .cdb_grant   (cdb_grant),
      .cdb_result  (cdb_result),
      .cdb_tag     (cdb_tag),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic [2:0]  tag;
   } sb_t;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   sb_t  sb_q[$];
   vec_t vt[19];

   int n_cmp = 0;
   int n_bad = 0;
   int acc_cnt = 0;
   int pop_cnt = 0;
   bit popped;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One cycle: drive at negedge, sample, update scoreboard before next edge.
   task automatic step(input logic v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] tag, input logic [31:0] exp,
                       input logic g, input logic f);
      sb_t e;
      @(negedge clk);
      issue_valid = v;
      issue_op    = op;
      issue_op1   = a;
      issue_op2   = b;
      issue_tag   = tag;
      cdb_grant   = g;
      flush       = f;
      #1;
      popped = 1'b0;
      if (f) begin
         sb_q.delete();
      end else begin
         if (cdb_req && g) begin
            popped = 1'b1;
            pop_cnt++;
            if (sb_q.size() == 0) begin
               check("unexpected_result", cdb_result, 32'hDEAD_BEEF);
            end else begin
               e = sb_q.pop_front();
               check("cdb_result", cdb_result, e.res);
               check("cdb_tag", 32'(cdb_tag), 32'(e.tag));
            end
         end
         if (v && issue_ready) begin
            e.res = exp;
            e.tag = tag;
            sb_q.push_back(e);
            acc_cnt++;
         end
      end
   endtask

   task automatic idle(input int n, input logic g);
      repeat (n) step(1'b0, 4'd0, 32'd0, 32'd0, 3'd0, 32'd0, g, 1'b0);
   endtask

   initial begin
      int pc0;
      int acc0;
      int drops;
      int first_pop;
      int last_pop;

      vt[0]  = '{4'd0,  32'h8000_0000, 32'h0000_0004, 32'h8000_0004};
      vt[1]  = '{4'd1,  32'h8000_0000, 32'h0000_0004, 32'h7FFF_FFFC};
      vt[2]  = '{4'd2,  32'h8000_0000, 32'h0000_0004, 32'h0000_0000};
      vt[3]  = '{4'd3,  32'h8000_0000, 32'h0000_0004, 32'h0000_0001};
      vt[4]  = '{4'd4,  32'h8000_0000, 32'h0000_0004, 32'h0000_0000};
      vt[5]  = '{4'd5,  32'h8000_0000, 32'h0000_0004, 32'h8000_0004};
      vt[6]  = '{4'd6,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000};
      vt[7]  = '{4'd7,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
      vt[8]  = '{4'd8,  32'h8000_0000, 32'h0000_0004, 32'h8000_0004};
      vt[9]  = '{4'd9,  32'h8000_0000, 32'h0000_0004, 32'h0000_0000};
      vt[10] = '{4'd10, 32'h8000_0000, 32'h0000_0004, 32'h0000_0004};
      vt[11] = '{4'd15, 32'h8000_0000, 32'h0000_0004, 32'h0000_0000};
      vt[12] = '{4'd11, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000};
      vt[13] = '{4'd1,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE};
      vt[14] = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
      vt[15] = '{4'd2,  32'h0000_0001, 32'h0000_003F, 32'h8000_0000};
      vt[16] = '{4'd7,  32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF};
      vt[17] = '{4'd3,  32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0000};
      vt[18] = '{4'd4,  32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0001};

      rst_n = 1'b0;
      flush = 1'b0;
      issue_valid = 1'b0;
      issue_op1 = '0;
      issue_op2 = '0;
      issue_op = '0;
      issue_tag = '0;
      cdb_grant = 1'b0;
      #12;
      check("rst_issue_ready", 32'(issue_ready), 32'd1);
      check("rst_cdb_req", 32'(cdb_req), 32'd0);
      check("rst_cdb_result", cdb_result, 32'd0);
      check("rst_cdb_tag", 32'(cdb_tag), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // single ADD latency, grant held high
      step(1'b1, 4'd0, 32'd5, 32'd7, 3'd3, 32'd12, 1'b1, 1'b0);
      for (int c = 1; c <= LAT + 1; c++) begin
         idle(1, 1'b1);
         check("req_latency", 32'(cdb_req), 32'(c == LAT));
      end
      check("single_busy_idle", 32'(busy), 32'd0);

      // op table under continuous grant
      pc0 = pop_cnt;
      for (int i = 0; i < 19; i++)
         step(1'b1, vt[i].op, vt[i].a, vt[i].b, 3'(i), vt[i].exp, 1'b1, 1'b0);
      idle(LAT + 3, 1'b1);
      check("table_pops", 32'(pop_cnt - pc0), 32'd19);

      // backpressure: grant low, issue held high
      acc0 = acc_cnt;
      for (int i = 0; i < 8; i++)
         step(1'b1, 4'd0, 32'(100 + i), 32'(i), 3'(i), 32'(100 + 2 * i),
              1'b0, 1'b0);
      check("full_accepts", 32'(acc_cnt - acc0), 32'd4);
      check("full_ready", 32'(issue_ready), 32'd0);
      check("full_req", 32'(cdb_req), 32'd1);
      step(1'b0, 4'd0, 32'd0, 32'd0, 3'd0, 32'd0, 1'b1, 1'b0);
      step(1'b0, 4'd0, 32'd0, 32'd0, 3'd0, 32'd0, 1'b0, 1'b0);
      check("ready_after_pop", 32'(issue_ready), 32'd1);
      idle(6, 1'b1);
      check("full_drained", 32'(sb_q.size()), 32'd0);

      // streaming 20 ops with continuous grant
      pc0 = pop_cnt;
      drops = 0;
      first_pop = -1;
      last_pop = -1;
      for (int i = 0; i < 20 + LAT + 3; i++) begin
         step(i < 20, 4'd0, 32'(i * 3), 32'd1000, 3'(i), 32'(i * 3 + 1000),
              1'b1, 1'b0);
         if (i < 20 && !issue_ready) drops++;
         if (popped) begin
            if (first_pop < 0) first_pop = i;
            last_pop = i;
         end
      end
      check("stream_ready_drops", 32'(drops), 32'd0);
      check("stream_pops", 32'(pop_cnt - pc0), 32'd20);
      check("stream_rate", 32'(last_pop - first_pop), 32'd19);

      // flush with ops in S1, S2 and FIFO, concurrent grant and issue
      step(1'b1, 4'd0, 32'd1, 32'd1, 3'd1, 32'd2, 1'b0, 1'b0);
      step(1'b1, 4'd0, 32'd2, 32'd2, 3'd2, 32'd4, 1'b0, 1'b0);
      step(1'b1, 4'd0, 32'd3, 32'd3, 3'd3, 32'd6, 1'b0, 1'b0);
      step(1'b1, 4'd0, 32'd4, 32'd4, 3'd4, 32'd8, 1'b0, 1'b0);
      check("preflush_req", 32'(cdb_req), 32'd1);
      step(1'b1, 4'd0, 32'd5, 32'd5, 3'd5, 32'd10, 1'b1, 1'b1);
      pc0 = pop_cnt;
      idle(1, 1'b1);
      check("flush_req", 32'(cdb_req), 32'd0);
      check("flush_busy", 32'(busy), 32'd0);
      check("flush_ready", 32'(issue_ready), 32'd1);
      check("flush_result", cdb_result, 32'd0);
      idle(5, 1'b1);
      check("flush_no_stale", 32'(pop_cnt - pc0), 32'd0);

      // asynchronous reset mid-burst
      for (int i = 0; i < 3; i++)
         step(1'b1, 4'd1, 32'd50, 32'(i), 3'(i), 32'(50 - i), 1'b1, 1'b0);
      @(negedge clk);
      issue_valid = 1'b0;
      cdb_grant = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      check("arst_issue_ready", 32'(issue_ready), 32'd1);
      check("arst_cdb_req", 32'(cdb_req), 32'd0);
      check("arst_cdb_result", cdb_result, 32'd0);
      check("arst_cdb_tag", 32'(cdb_tag), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      pc0 = pop_cnt;
      step(1'b1, 4'd0, 32'd40, 32'd2, 3'd5, 32'd42, 1'b1, 1'b0);
      idle(LAT + 2, 1'b1);
      check("post_rst_pops", 32'(pop_cnt - pc0), 32'd1);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_req", 32'(cdb_req), 32'd0);

      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
